// File: rtl/camera_capture_ctrl.sv
// OV7670 capture sequencer: arms on start, aligns to a vsync boundary, gates cap_en
// for one or every frame and checks line/byte geometry. All outputs registered, no backpressure.
module camera_capture_ctrl #(
  parameter int EXP_LINES = 480,
  parameter int EXP_BYTES = 1280,
  parameter int TIMEOUT   = 1048575
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  input  logic       abort,
  input  logic       vsync,
  input  logic       href,
  output logic       cap_en,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] frame_cnt,
  output logic [9:0] line_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [9:0]    EXP_LINES_C = 10'(EXP_LINES);
  localparam logic [10:0]   EXP_BYTES_C = 11'(EXP_BYTES);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SYNC, WAIT_START, ACTIVE} state_e;

  state_e      state_q, state_d;
  logic        vsync_q, href_q;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic        berr_q, berr_d;
  logic [9:0]  line_cnt_q, line_cnt_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;
  logic        cap_en_q, cap_en_d;
  logic        busy_q, busy_d;

  logic        vs_rise, vs_fall, hr_rise, hr_fall;
  logic        berr_now, frame_end, timeout_hit;
  logic [1:0]  frame_code;

  assign vs_rise = vsync & ~vsync_q;
  assign vs_fall = ~vsync & vsync_q;
  assign hr_rise = href & ~href_q;
  assign hr_fall = ~href & href_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vsync_q      <= 1'b1;
      href_q       <= 1'b0;
      tmo_q        <= '0;
      byte_cnt_q   <= '0;
      berr_q       <= 1'b0;
      line_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      err_code_q   <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      cap_en_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync;
      href_q       <= href;
      tmo_q        <= tmo_d;
      byte_cnt_q   <= byte_cnt_d;
      berr_q       <= berr_d;
      line_cnt_q   <= line_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      err_code_q   <= err_code_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      cap_en_q     <= cap_en_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    byte_cnt_d   = byte_cnt_q;
    berr_d       = berr_q;
    line_cnt_d   = line_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    err_code_d   = err_code_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    frame_code   = 2'd0;

    // A line ending on the frame-end cycle must still count toward the byte error.
    berr_now    = berr_q | (hr_fall && (byte_cnt_q != EXP_BYTES_C));
    frame_end   = (state_q == ACTIVE) && vs_rise;
    timeout_hit = (state_q != IDLE) && !vs_rise && !vs_fall && (tmo_q == TMO_LAST);

    if (state_q != IDLE) begin
      tmo_d = (vs_rise || vs_fall) ? '0 : tmo_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SYNC;
          err_code_d = 2'd0;
          line_cnt_d = '0;
          tmo_d      = '0;
        end
      end
      SYNC: begin
        if (vsync) state_d = WAIT_START;
      end
      WAIT_START: begin
        if (vs_fall) begin
          state_d    = ACTIVE;
          line_cnt_d = '0;
          byte_cnt_d = '0;
          berr_d     = 1'b0;
        end
      end
      ACTIVE: begin
        if (hr_rise) begin
          if (line_cnt_q != 10'h3FF) line_cnt_d = line_cnt_q + 10'd1;
          byte_cnt_d = 11'd1;
        end else if (href && (byte_cnt_q != 11'h7FF)) begin
          byte_cnt_d = byte_cnt_q + 11'd1;
        end
        if (hr_fall) berr_d = berr_now;
        if (frame_end) begin
          if (berr_now)                        frame_code = 2'd2;
          else if (line_cnt_q != EXP_LINES_C)  frame_code = 2'd1;
          else                                 frame_code = 2'd0;
          err_code_d   = frame_code;
          frame_done_d = 1'b1;
          frame_err_d  = (frame_code != 2'd0);
          if (frame_code == 2'd0) frame_cnt_d = frame_cnt_q + 8'd1;
          state_d = continuous ? WAIT_START : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout_hit) begin
      state_d     = IDLE;
      err_code_d  = 2'd3;
      frame_err_d = 1'b1;
    end

    if (abort) begin
      state_d      = IDLE;
      err_code_d   = err_code_q;
      frame_cnt_d  = frame_cnt_q;
      line_cnt_d   = line_cnt_q;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;
    end

    cap_en_d = (state_d == ACTIVE);
    busy_d   = (state_d != IDLE);
  end

  assign cap_en     = cap_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign frame_cnt  = frame_cnt_q;
  assign line_cnt   = line_cnt_q;

endmodule

// File: doc/camera_capture_ctrl.md
# camera_capture_ctrl

Sequencing controller for the OV7670 capture path. Sits between the system control logic and the downsampling capture datapath: it arms capture on request, aligns it to a clean frame boundary, gates the datapath's write enable for exactly one frame (single-shot) or for every frame (continuous), and checks frame geometry against expected sizes. It reports busy, done, error and a frame counter to the rest of the design.

## Interface
- EXP_LINES, 480: expected href-high lines per frame.
- EXP_BYTES, 1280: expected pclk cycles with href high per line (2 bytes per pixel, 640 px).
- TIMEOUT, 1048575: max pclk cycles between vsync edges while armed or active.
- pclk  in  1  camera pixel clock; single clock of the block.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin capture; ignored while busy.
- continuous  in  1  level; sampled at every frame end; 1 = re-arm automatically.
- abort  in  1  one-cycle request to stop immediately.
- vsync  in  1  camera vsync, synchronous to pclk; high = vertical blanking.
- href  in  1  camera href, synchronous to pclk; high = valid line bytes.
- cap_en  out  1  enables the capture datapath / DPRAM writes.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse at end of each captured frame (good or bad).
- frame_err  out  1  one-cycle pulse, coincident with frame_done or timeout, when err_code != 0.
- err_code  out  2  0 none, 1 line-count mismatch, 2 byte-count mismatch, 3 timeout; held until next start.
- frame_cnt  out  8  count of error-free frames since reset; wraps 255 -> 0.
- line_cnt  out  10  lines seen in current/last frame; saturates at 1023.

## Operation
- Edge detect: vsync_q, href_q registered copies; rise = in & !q, fall = !in & q, evaluated same cycle as input.
- States: IDLE, SYNC, WAIT_START, ACTIVE.
- IDLE: cap_en=0, busy=0. start -> SYNC; err_code cleared to 0, line_cnt cleared.
- SYNC: wait for vsync high (blanking). vsync==1 -> WAIT_START. Guarantees capture never begins mid-frame.
- WAIT_START: vsync fall -> ACTIVE; line_cnt, byte counter, error flags cleared.
- ACTIVE: cap_en=1. href rise -> line_cnt+1 (saturating), byte counter reset to 1. href high and not rise -> byte counter+1 (11-bit, saturating 2047). href fall -> if byte counter != EXP_BYTES set byte-error flag (sticky for frame).
- ACTIVE, vsync rise (frame end): frame_done pulse; err_code = 2 if byte-error flag, else 1 if line_cnt != EXP_LINES, else 0; frame_err pulses if nonzero; frame_cnt+1 only if 0. Next state: continuous ? WAIT_START : IDLE (vsync is high, so WAIT_START is correctly aligned).
- Timeout: cycle counter in SYNC/WAIT_START/ACTIVE, cleared on any vsync edge and on entry; reaching TIMEOUT -> err_code=3, frame_err pulse (no frame_done), -> IDLE.
- abort: from any state -> IDLE; no done/err pulse; err_code and counters unchanged.
- Simultaneous: abort beats start and frame end; frame end beats timeout on same cycle; start in non-IDLE ignored.

## Timing
- Reset values: state IDLE, cap_en 0, busy 0, frame_done 0, frame_err 0, err_code 0, frame_cnt 0, line_cnt 0, vsync_q 1, href_q 0.
- All outputs registered. start in cycle N -> busy=1 in N+1.
- vsync fall in cycle N -> cap_en=1 in N+1. vsync rise in N -> cap_en=0, frame_done=1 in N+1; frame_done low in N+2.
- abort in N -> cap_en=0, busy=0 in N+1.
- Line counted on href rise cycle; line_cnt visible next cycle. Byte check on href fall cycle.
- rst_n low mid-frame: all outputs to reset values asynchronously; after release, remains IDLE until start.

## Test plan
- EXP_LINES=4, EXP_BYTES=8; start during active frame, continuous=0, then clean 4x8 frame -> cap_en stays 0 until next vsync fall, one frame_done, err_code=0, frame_cnt=1, busy=0 after.
- continuous=1, three clean frames, continuous dropped during frame 3 -> three frame_done pulses, frame_cnt=3, IDLE after frame 3 end.
- Frame with 3 lines -> frame_done + frame_err, err_code=1, frame_cnt unchanged, line_cnt=3; frame with one 7-byte line and 4 lines -> err_code=2.
- TIMEOUT=1000, start, vsync held low -> frame_err at cycle 1000 after last edge, err_code=3, no frame_done, busy=0.
- abort mid-ACTIVE, and abort+start same cycle in IDLE -> cap_en=0/busy=0 next cycle, no pulses, stays IDLE.
- rst_n asserted mid-ACTIVE -> all outputs immediately at reset values; start after release captures next full frame normally.
